// File: rtl/mips_multicycle_ctrl_if.sv
// Control-path bundle between the multi-cycle MIPS main FSM and the datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             jreg;
  logic             zero;
  logic             mem_ready;

  logic             pc_en;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_retired;
  logic [3:0]       state;

  modport master (
    input  opcode, jreg, zero, mem_ready,
    output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, instr_retired, state
  );

  modport slave (
    output opcode, jreg, zero, mem_ready,
    input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, instr_retired, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: fetch, decode, execute,
// memory access and writeback, with a mem_ready stall and a retire counter.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  // NOTE: state is updated with non-blocking assignments so every process
  // samples the pre-edge value on the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_ONE;
  end

  // Next state and the retire strobe for the instruction leaving this cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (bus.jreg) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB, S_BRANCH, S_JUMP, S_IWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_IEXEC: state_d = S_IWB;
      default: state_d = S_FETCH;
    endcase
  end

  // Control word, decoded from state; everything is forced low during reset.
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_source  = 2'b00;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 3'b000;
    bus.illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_en     = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI: ;
            default: bus.illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 3'b100;
          if (bus.jreg) begin
            bus.pc_en     = 1'b1;
            bus.pc_source = 2'b11;
          end
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 3'b001;
          bus.pc_source = 2'b01;
          bus.pc_en     = bus.zero;
        end
        S_JUMP: begin
          bus.pc_source = 2'b10;
          bus.pc_en     = 1'b1;
        end
        S_IEXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = (bus.opcode == OP_ANDI) ? 3'b011 : 3'b000;
        end
        S_IWB: bus.reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: each instruction is expanded into
// its cycle-by-cycle control trace and compared against the DUT every cycle.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctrl_t observed();
    ctrl_t o;
    o.pc_en      = bus.pc_en;
    o.pc_source  = bus.pc_source;
    o.i_or_d     = bus.i_or_d;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] exp_count();
    return 32'(model_cnt % (1 << CNT_W));
  endfunction

  // Compares the full visible state of the DUT against the model.
  task automatic compare_all(input string tag, input int exp_state, input ctrl_t exp);
    check({tag, ".state"}, 32'(bus.state), 32'(exp_state));
    check({tag, ".ctrl"}, 32'(observed()), 32'(exp));
    check({tag, ".retired"}, 32'(bus.instr_retired), exp_count());
    check({tag, ".rd_wr_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
  endtask

  // One clock cycle: drive inputs after the falling edge, then compare.
  task automatic step(input string tag, input int exp_state, input ctrl_t exp,
                      input logic mr, input logic jr, input logic z,
                      input logic [5:0] op);
    @(negedge clk);
    bus.mem_ready = mr;
    bus.jreg      = jr;
    bus.zero      = z;
    bus.opcode    = op;
    #1;
    compare_all(tag, exp_state, exp);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI};
  endfunction

  // Runs one instruction: fw/mw are the number of cycles memory stalls during
  // fetch and data access, jr_v and z_v are the jreg/zero values it sees.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic jr_v, input logic z_v);
    ctrl_t c;
    for (int w = 0; w <= fw; w++) begin
      c = '0;
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write  = (w == fw);
      c.pc_en     = (w == fw);
      step("fetch", 0, c, (w == fw), rbit(), rbit(), 6'($urandom));
    end

    c = '0;
    c.alu_src_b  = 2'b11;
    c.illegal_op = !is_legal(op);
    step("decode", 1, c, rbit(), rbit(), rbit(), op);
    if (!is_legal(op)) return;

    case (op)
      OP_LW, OP_SW: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        step("memadr", 2, c, rbit(), rbit(), rbit(), op);
        for (int w = 0; w <= mw; w++) begin
          c = '0;
          c.i_or_d    = 1'b1;
          c.mem_read  = (op == OP_LW);
          c.mem_write = (op == OP_SW);
          step(op == OP_LW ? "memrd" : "memwr", op == OP_LW ? 3 : 5, c,
               (w == mw), rbit(), rbit(), op);
        end
        if (op == OP_LW) begin
          c = '0;
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          step("memwb", 4, c, rbit(), rbit(), rbit(), op);
        end
        model_cnt++;
      end
      OP_RTYPE: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b100;
        if (jr_v) begin
          c.pc_en     = 1'b1;
          c.pc_source = 2'b11;
        end
        step("exec", 6, c, rbit(), jr_v, rbit(), op);
        if (!jr_v) begin
          c = '0;
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
          step("aluwb", 7, c, rbit(), rbit(), rbit(), op);
        end
        model_cnt++;
      end
      OP_BEQ: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b001;
        c.pc_source = 2'b01;
        c.pc_en     = z_v;
        step("branch", 8, c, rbit(), rbit(), z_v, op);
        model_cnt++;
      end
      OP_J: begin
        c = '0;
        c.pc_source = 2'b10;
        c.pc_en     = 1'b1;
        step("jump", 9, c, rbit(), rbit(), rbit(), op);
        model_cnt++;
      end
      default: begin
        c = '0;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_ANDI) ? 3'b011 : 3'b000;
        step("iexec", 10, c, rbit(), rbit(), rbit(), op);
        c = '0;
        c.reg_write = 1'b1;
        step("iwb", 11, c, rbit(), rbit(), rbit(), op);
        model_cnt++;
      end
    endcase
  endtask

  // lw up to MEMRD, then reset with mem_ready high: nothing may be issued.
  task automatic reset_mid_memrd();
    ctrl_t c;
    c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_en = 1'b1;
    step("rst_fetch", 0, c, 1'b1, 1'b0, 1'b0, OP_LW);
    c = '0;
    c.alu_src_b = 2'b11;
    step("rst_decode", 1, c, 1'b1, 1'b0, 1'b0, OP_LW);
    c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    step("rst_memadr", 2, c, 1'b1, 1'b0, 1'b0, OP_LW);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    model_cnt = 0;
    #1;
    compare_all("rst_hold0", 0, '0);
    @(negedge clk);
    #1;
    compare_all("rst_hold1", 0, '0);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    compare_all("rst_release", 0, c);
  endtask

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI};

    rst = 1'b1;
    bus.opcode = '0; bus.jreg = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    compare_all("reset", 0, '0);
    bus.mem_ready = 1'b0;
    rst = 1'b0;

    run_instr(OP_LW,    0, 0, 1'b0, 1'b0);
    run_instr(OP_SW,    0, 3, 1'b0, 1'b0);
    run_instr(OP_RTYPE, 0, 0, 1'b1, 1'b0);
    run_instr(OP_RTYPE, 1, 0, 1'b0, 1'b0);
    run_instr(OP_BEQ,   0, 0, 1'b0, 1'b1);
    run_instr(OP_BEQ,   0, 0, 1'b0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0, 1'b0);
    run_instr(OP_ANDI,  0, 0, 1'b0, 1'b0);
    run_instr(OP_ADDI,  2, 0, 1'b0, 1'b0);
    run_instr(OP_J,     0, 0, 1'b0, 1'b0);
    run_instr(OP_LW,    2, 3, 1'b0, 1'b0);

    reset_mid_memrd();

    // Random mix; with a 4-bit counter this wraps several times.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else                           op = legal_ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core.
- Sequences instruction fetch, decode, execute, memory access and writeback.
- Drives the 3-bit alu_op consumed by alu_control, and takes back its jreg flag to resolve JR.
- Supports R-type (add/sub/sll/nor/and/slt/jr), lw, sw, beq, j, addi and andi.
- Memory accesses stall on a mem_ready handshake; retired instructions are counted.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE onward.
- jreg  in  1  from alu_control; valid while alu_op=3'b100.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_en  out  1  PC load enable.
- pc_source  out  2  PC mux select: 00 ALU result, 01 ALUOut (branch target), 10 jump address, 11 rs (JR).
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write-register select: 1 rd, 0 rt.
- mem_to_reg  out  1  writeback data select: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- alu_op  out  3  to alu_control: 100 R-type, 000 add, 001 sub, 011 and.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- instr_retired  out  CNT_W  retired-instruction count.
- state  out  4  current FSM state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12–15 go to FETCH.
- Outputs are decoded combinationally from state, plus jreg, zero and mem_ready where noted. Any output not listed for a state is 0.
- Reset:
  - While rst=1: state=FETCH, instr_retired=0, and every output is 0 (strobes gated by rst).
  - Reset asserted mid-instruction abandons the instruction; no partial write is issued after the rst edge.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write = pc_en = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000 (precompute branch target).
  - Next state by opcode: 000000→EXEC; 100011 or 101011→MEMADR; 000100→BRANCH; 000010→JUMP; 001000 or 001100→IEXEC.
  - Any other opcode: illegal_op=1 this cycle, next FETCH, instr_retired unchanged.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=000.
  - Next: lw→MEMRD, sw→MEMWR.
- MEMRD:
  - Outputs: mem_read=1, i_or_d=1.
  - Wait for mem_ready=1, then go to MEMWB.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Retire; next FETCH.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1.
  - Wait for mem_ready=1, then retire; next FETCH.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=100.
  - If jreg=1: pc_en=1, pc_source=11, retire, next FETCH.
  - Else: next ALUWB.
- ALUWB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Retire; next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_en=zero.
  - Retire; next FETCH.
- JUMP:
  - Outputs: pc_source=10, pc_en=1.
  - Retire; next FETCH.
- IEXEC:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - alu_op=000 for addi, 011 for andi.
  - Next IWB.
- IWB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Retire; next FETCH.
- Retire: instr_retired increments by 1 on the clock edge leaving the retiring state. It wraps from all-ones to 0.
- mem_read and mem_write are never asserted in the same cycle.
- Memory requests stay asserted continuously until mem_ready. mem_ready in any other state is ignored.
- Instruction latency with mem_ready tied to 1, in cycles: lw 5; sw 4; R-type 4; addi/andi 4; beq 3; j 3; jr 3.

Test Plan:
- Reset mid-MEMRD with mem_ready tied to 1 → all outputs 0 while rst=1; after release state=0 and mem_read=1 with i_or_d=0.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_retired=1.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write held high for 4 cycles; no reg_write; count +1.
- R-type with jreg=1 (funct 001000) → EXEC has pc_en=1, pc_source=11, no ALUWB. R-type with jreg=0 → ALUWB has reg_write=1, reg_dst=1.
- beq with zero=1, then again with zero=0 → pc_en=1 then pc_en=0 in BRANCH; alu_op=001 both times.
- Opcode 111111 → illegal_op pulses 1 cycle in DECODE, then FETCH, count unchanged. andi → alu_op=011 in IEXEC. Counter preset near all-ones by running 2^CNT_W instructions with a reduced CNT_W=4 → wraps to 0.
